// File: rtl/dmem_responder.sv
// dmem_responder: byte-addressed 16-bit data memory target with fixed wait states and a one-cycle response.
// Optional misaligned word-access fault checking is enabled by defining DMEM_RESP_ALIGN_CHK_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYC    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [15:0] DEPTH_L  = 16'(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic        byte_q, byte_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [15:0] mem [DEPTH_WORDS];

    logic        cur_write, cur_byte;
    logic [15:0] cur_addr, cur_wdata;
    logic [AW-1:0] widx;
    logic        oor, fault, enter_resp, mem_we;
    logic [15:0] rd_word, wr_word;
    logic [7:0]  rd_lane;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        byte_d     = byte_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;

        req_ready  = (state_q == ST_IDLE);
        busy       = (state_q != ST_IDLE);
        rsp_valid  = (state_q == ST_RESP);
        rsp_rdata  = rdata_q;
        rsp_err    = err_q;

        // With zero wait states the access completes on the acceptance edge, so use the live request.
        cur_write = (state_q == ST_IDLE) ? req_write : write_q;
        cur_byte  = (state_q == ST_IDLE) ? req_byte  : byte_q;
        cur_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
        cur_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;

        widx = cur_addr[AW:1];
        oor  = ({1'b0, cur_addr[15:1]} >= DEPTH_L);
`ifdef DMEM_RESP_ALIGN_CHK_EN
        fault = oor || (!cur_byte && cur_addr[0]);
`else
        fault = oor;
`endif

        rd_word = mem[widx];
        rd_lane = cur_addr[0] ? rd_word[15:8] : rd_word[7:0];
        if (!cur_byte) begin
            wr_word = cur_wdata;
        end else if (cur_addr[0]) begin
            wr_word = {cur_wdata[7:0], rd_word[7:0]};
        end else begin
            wr_word = {rd_word[15:8], cur_wdata[7:0]};
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    byte_d  = req_byte;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (WAIT_CYC == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (enter_resp) begin
            err_d = fault;
            if (fault || cur_write) begin
                rdata_d = 16'h0000;
            end else if (cur_byte) begin
                rdata_d = {8'h00, rd_lane};
            end else begin
                rdata_d = rd_word;
            end
        end

        // Reset on the commit edge abandons the store.
        mem_we = enter_resp && cur_write && !fault && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        write_q <= write_d;
        byte_q  <= byte_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[widx] <= wr_word;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table, byte-array reference model, reset corner cases.
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_write, req_byte;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [15:0] rsp_rdata;

    logic        z_valid, z_write, z_byte;
    logic [15:0] z_addr, z_wdata;
    logic        z_ready, z_rsp_valid, z_err, z_busy;
    logic [15:0] z_rdata;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYC(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYC(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_valid), .req_ready(z_ready), .req_write(z_write),
        .req_byte(z_byte), .req_addr(z_addr), .req_wdata(z_wdata),
        .rsp_valid(z_rsp_valid), .rsp_rdata(z_rdata), .rsp_err(z_err), .busy(z_busy)
    );

`ifdef DMEM_RESP_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] mdl [512];

    typedef struct {
        bit          wr;
        bit          by;
        logic [15:0] a;
        logic [15:0] wd;
        logic [15:0] rd;
        bit          e;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 263) ^ 16'hA55A;
    endfunction

    function automatic bit m_fault(input bit by, input logic [15:0] a);
        return (a[15:1] >= 15'd256) || (ALIGN && !by && a[0]);
    endfunction

    task automatic m_apply(input bit wr, input bit by, input logic [15:0] a, input logic [15:0] wd,
                           output logic [15:0] rd, output bit e);
        int base;
        base = int'(a) & ~1;
        e    = m_fault(by, a);
        rd   = 16'h0000;
        if (!e) begin
            if (wr) begin
                if (by) begin
                    mdl[int'(a)] = wd[7:0];
                end else begin
                    mdl[base]     = wd[7:0];
                    mdl[base + 1] = wd[15:8];
                end
            end else if (by) begin
                rd = {8'h00, mdl[int'(a)]};
            end else begin
                rd = {mdl[base + 1], mdl[base]};
            end
        end
    endtask

    // Called at a negedge; returns at the negedge of the idle cycle following the response.
    task automatic txn(input bit wr, input bit by, input logic [15:0] a, input logic [15:0] wd,
                       output logic [15:0] rd, output logic e, output int lat, output int bcnt);
        int n;
        rd = 16'h0000; e = 1'b1; lat = -1; bcnt = 0; n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_byte = by; req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_byte  = 1'($urandom_range(0, 1));
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        for (int i = 1; i <= 20; i++) begin
            if (busy) bcnt++;
            if (rsp_valid) begin
                lat = i;
                rd  = rsp_rdata;
                e   = rsp_err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (lat > 0) begin
            chk("post_resp_ready", 32'(req_ready), 32'd1);
            chk("post_resp_busy", 32'(busy), 32'd0);
            chk("post_resp_valid", 32'(rsp_valid), 32'd0);
            chk("rdata_hold", 32'(rsp_rdata), 32'(rd));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd, mrd, iv24, iv255;
        logic        e;
        bit          me;
        int          lat, bcnt, seen, acc;
        bit          wr, by;
        logic [15:0] a, wd;

        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_addr = '0; req_wdata = '0;
        z_valid = 1'b0; z_write = 1'b0; z_byte = 1'b0; z_addr = '0; z_wdata = '0;
        iv24  = init_val(24);
        iv255 = init_val(255);

        tbl[0]  = '{1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 16'h0020, 16'h1234, 16'h0000, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 16'h0021, 16'hCDAB, 16'h0000, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 16'h0020, 16'h0000, 16'h0034, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 16'h0021, 16'h0000, 16'h00AB, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'hAB34, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 16'h0200, 16'h0000, 16'h0000, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 16'h0200, 16'hFFFF, 16'h0000, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, init_val(0), 1'b0};
        tbl[10] = '{1'b1, 1'b0, 16'h0031, 16'h7777, 16'h0000, ALIGN};
        tbl[11] = '{1'b0, 1'b0, 16'h0030, 16'h0000, (ALIGN ? iv24 : 16'h7777), 1'b0};
        tbl[12] = '{1'b0, 1'b1, 16'h0031, 16'h0000, (ALIGN ? {8'h00, iv24[15:8]} : 16'h0077), 1'b0};
        tbl[13] = '{1'b0, 1'b0, 16'h0031, 16'h0000, (ALIGN ? 16'h0000 : 16'h7777), ALIGN};
        tbl[14] = '{1'b1, 1'b1, 16'h0201, 16'h00EE, 16'h0000, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 16'h01FF, 16'h0000, {8'h00, iv255[15:8]}, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 16'h01FE, 16'h0000, iv255, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rdata", 32'(rsp_rdata), 32'd0);
        chk("reset_err", 32'(rsp_err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 256; i++) begin
            txn(1'b1, 1'b0, 16'(2 * i), init_val(i), rd, e, lat, bcnt);
            m_apply(1'b1, 1'b0, 16'(2 * i), init_val(i), mrd, me);
        end

        foreach (tbl[i]) begin
            txn(tbl[i].wr, tbl[i].by, tbl[i].a, tbl[i].wd, rd, e, lat, bcnt);
            m_apply(tbl[i].wr, tbl[i].by, tbl[i].a, tbl[i].wd, mrd, me);
            chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(tbl[i].rd));
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].e));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd3);
        end

        for (int i = 0; i < 80; i++) begin
            wr = 1'($urandom_range(0, 1));
            by = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 7) == 0) ? (16'($urandom) | 16'h0200) : 16'($urandom_range(0, 511));
            wd = 16'($urandom);
            m_apply(wr, by, a, wd, mrd, me);
            txn(wr, by, a, wd, rd, e, lat, bcnt);
            chk($sformatf("rand%0d_rdata", i), 32'(rd), 32'(mrd));
            chk($sformatf("rand%0d_err", i), 32'(e), 32'(me));
            chk($sformatf("rand%0d_latency", i), 32'(lat), 32'd3);
        end

        // Reset during the first wait cycle abandons the store.
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_addr = 16'h0040; req_wdata = 16'h1111;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("wait_rst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("wait_rst_ready", 32'(req_ready), 32'd1);
        chk("wait_rst_busy", 32'(busy), 32'd0);
        chk("wait_rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("wait_rst_err", 32'(rsp_err), 32'd0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        chk("wait_rst_no_rsp", 32'(seen), 32'd0);
        m_apply(1'b0, 1'b0, 16'h0040, 16'h0000, mrd, me);
        txn(1'b0, 1'b0, 16'h0040, 16'h0000, rd, e, lat, bcnt);
        chk("wait_rst_word_unchanged", 32'(rd), 32'(mrd));

        // Reset and request together: nothing is accepted.
        rst = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_addr = 16'h0044; req_wdata = 16'h2222;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        chk("rst_valid_busy", 32'(busy), 32'd0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid || busy) seen++;
            @(negedge clk);
        end
        chk("rst_valid_no_txn", 32'(seen), 32'd0);
        m_apply(1'b0, 1'b0, 16'h0044, 16'h0000, mrd, me);
        txn(1'b0, 1'b0, 16'h0044, 16'h0000, rd, e, lat, bcnt);
        chk("rst_valid_word_unchanged", 32'(rd), 32'(mrd));

        // Reset in the response cycle: the store is already committed.
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_addr = 16'h0046; req_wdata = 16'h3333;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            if (rsp_valid) seen = 1;
            else @(negedge clk);
        end
        chk("resp_rst_reached_resp", 32'(seen), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("resp_rst_valid_cleared", 32'(rsp_valid), 32'd0);
        m_apply(1'b1, 1'b0, 16'h0046, 16'h3333, mrd, me);
        txn(1'b0, 1'b0, 16'h0046, 16'h0000, rd, e, lat, bcnt);
        chk("resp_rst_store_committed", 32'(rd), 32'h3333);

        // Zero wait states: back-to-back requests alternate ready and response.
        z_valid = 1'b1; z_write = 1'b0; z_byte = 1'b0; z_addr = 16'h0002;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("w0_ready_c%0d", i), 32'(z_ready), 32'((i % 2) == 0));
            chk($sformatf("w0_rsp_valid_c%0d", i), 32'(z_rsp_valid), 32'((i % 2) == 1));
            if (z_ready && z_valid) acc++;
            @(negedge clk);
        end
        z_valid = 1'b0;
        chk("w0_accepted", 32'(acc), 32'd3);
        chk("w0_err", 32'(z_err), 32'd0);
        chk("w0_idle_after", 32'(z_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder: the target end of the CPU's load/store path. It accepts one load or store per handshake from the memory stage, inserts a fixed number of wait states, commits or reads a byte-addressed 16-bit memory, and returns a single-cycle response. While a transaction is in flight it drives `busy` to the hazard-detection unit, which stalls the pipeline.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: number of 16-bit words stored; power of two, 2..32768.
- `WAIT_CYC`, 2: wait states inserted per access, 0..15.

Ports:
- `clk` input 1: the only clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: a request is presented.
- `req_ready` output 1: the responder can accept a request.
- `req_write` input 1: 1 = store, 0 = load.
- `req_byte` input 1: 1 = byte access, 0 = word access.
- `req_addr` input 16: byte address.
- `req_wdata` input 16: store data; byte stores use `[7:0]`.
- `rsp_valid` output 1: one-cycle pulse marking a completed access.
- `rsp_rdata` output 16: load data, valid with `rsp_valid`.
- `rsp_err` output 1: access fault, valid with `rsp_valid`.
- `busy` output 1: a transaction is in flight; feeds the stall logic.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. When `req_valid` is 1, capture `req_write`, `req_byte`, `req_addr` and `req_wdata`. Go to WAIT with counter = `WAIT_CYC`-1, or go straight to RESP if `WAIT_CYC`=0.
- WAIT: `req_ready`=0. Decrement the counter each cycle. Go to RESP on the edge where the counter is 0.
- RESP: `rsp_valid`=1 for exactly one cycle. Next state is always IDLE.
- Request inputs are ignored outside the IDLE acceptance edge.
- Addressing:
  - Word index = `req_addr[15:1]`.
  - Byte lanes are little-endian: `addr[0]`=0 selects `[7:0]`; `addr[0]`=1 selects `[15:8]`.
- Word load: `rsp_rdata` = the stored word.
- Byte load: `rsp_rdata` = {8'h00, selected byte}.
- Word store: writes all 16 bits.
- Byte store: writes `req_wdata[7:0]` into the selected lane only; the other lane is unchanged.
- Stores return `rsp_rdata`=0.
- Out of range (word index ≥ `DEPTH_WORDS`): `rsp_err`=1, the store is dropped, and a load returns 0.
- The store commit and the load read both happen on the edge entering RESP. A request accepted later therefore observes the store.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE, counter 0, `req_ready`=1 (combinational from IDLE), `rsp_valid`=0, `rsp_rdata`=16'h0000, `rsp_err`=0, `busy`=0. Memory contents are not cleared.
- Latency: `rsp_valid` is high in the cycle that starts `WAIT_CYC`+1 rising edges after the acceptance edge.
- Throughput: one request per `WAIT_CYC`+2 cycles. `req_ready` is low during WAIT and RESP and returns to 1 in the cycle after RESP.
- `rsp_rdata` and `rsp_err` hold their values after the `rsp_valid` pulse until the next RESP or reset.
- Reset in WAIT: the transaction is abandoned, the store is not committed, and no response is issued.
- Reset in RESP: the store has already committed; `rsp_valid` is cleared on that edge.
- `rst` and `req_valid` high together: reset wins and nothing is accepted.

## Configuration
- `DMEM_RESP_ALIGN_CHK_EN` defined:
  - A word access with `req_addr[0]`=1 is a misaligned fault.
  - The fault sets `rsp_err`=1, drops the store, and returns a load value of 0.
  - Latency is unchanged.
- `DMEM_RESP_ALIGN_CHK_EN` undefined:
  - `req_addr[0]` is ignored for word accesses, and the aligned word is accessed.
  - `rsp_err` reflects out-of-range faults only.

## Test plan
- Reset, then `WAIT_CYC`=2: word store 16'hBEEF to 16'h0010, then word load from 16'h0010. Response: `rsp_valid` 3 edges after each acceptance, load `rsp_rdata`=16'hBEEF, `rsp_err`=0, `busy` high 3 cycles per access.
- Word store 16'h1234 to 16'h0020, byte store 8'hAB to 16'h0021, then byte loads from 16'h0020 and 16'h0021, then a word load from 16'h0020. Response: 16'h0034, 16'h00AB, 16'hAB34.
- `WAIT_CYC`=0 with `req_valid` held high for 6 cycles. Response: 3 requests accepted, `rsp_valid` on alternate cycles, `req_ready` pattern 1,0,1,0,1,0.
- With `DEPTH_WORDS`=256: word load from 16'h0200 gives `rsp_err`=1 and `rsp_rdata`=0. A store to 16'h0200 is dropped, and a later load of 16'h0000 is unchanged.
- Word store to 16'h0031:
  - macro on: `rsp_err`=1 and word 16'h0030 is unchanged.
  - macro off: `rsp_err`=0 and word 16'h0030 is written.
- Store accepted, then `rst` asserted in the first WAIT cycle. Response: no `rsp_valid`, all outputs at reset values, and the target word is unchanged.
